// File: rtl/lwc_do_sink_if.sv
// Output-port bundle of the LWC core: data word, valid, last and ready.
// The core drives the master side; the capture sink uses the slave side.
interface lwc_do_sink_if #(
    parameter int BUSW = 32
) ();
    logic [BUSW-1:0] do_data;
    logic            do_valid;
    logic            do_last;
    logic            do_ready;

    modport master (
        output do_data,
        output do_valid,
        output do_last,
        input  do_ready
    );

    modport slave (
        input  do_data,
        input  do_valid,
        input  do_last,
        output do_ready
    );
endinterface

// File: rtl/lwc_do_sink.sv
// Capture sink for the LWC output stream: parses headers, payload and status,
// writes payload bytes to a byte-enabled memory port and reports results.
module lwc_do_sink #(
    parameter int BUSW  = 32,
    parameter int ADDRW = 8
) (
    input  logic               clk,
    input  logic               rst,
    lwc_do_sink_if.slave       dout,
    input  logic               stall,
    output logic               mem_we,
    output logic [ADDRW-1:0]   mem_addr,
    output logic [BUSW-1:0]    mem_wdata,
    output logic [BUSW/8-1:0]  mem_be,
    output logic [3:0]         seg_type,
    output logic [15:0]        seg_len,
    output logic               seg_done,
    output logic [15:0]        byte_cnt,
    output logic               status_valid,
    output logic               status_pass,
    output logic               err_proto
);

    localparam int NB = BUSW / 8;

    typedef enum logic {
        HDR  = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t           state;
    logic             ready_q;
    logic [15:0]      rem;
    logic [ADDRW-1:0] wr_ptr;

    logic             acc;
    logic [3:0]       hdr_type;
    logic [15:0]      hdr_len;
    logic             is_status;
    logic [15:0]      take;
    logic [15:0]      rem_next;
    logic [NB-1:0]    be_mask;

    assign dout.do_ready = ready_q;
    assign acc           = dout.do_valid & ready_q;
    assign hdr_type      = dout.do_data[BUSW-1 -: 4];
    assign hdr_len       = dout.do_data[15:0];
    assign is_status     = (hdr_type[3:1] == 3'b111);

    // Bytes consumed by this word; the final word of a segment may be partial.
    always_comb begin
        take     = (rem < 16'(NB)) ? rem : 16'(NB);
        rem_next = rem - take;
        be_mask  = ~({NB{1'b1}} >> take);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= HDR;
            ready_q      <= 1'b0;
            rem          <= '0;
            wr_ptr       <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            seg_type     <= '0;
            seg_len      <= '0;
            seg_done     <= 1'b0;
            byte_cnt     <= '0;
            status_valid <= 1'b0;
            status_pass  <= 1'b0;
            err_proto    <= 1'b0;
        end else begin
            ready_q      <= ~stall;
            mem_we       <= 1'b0;
            seg_done     <= 1'b0;
            status_valid <= 1'b0;
            if (acc) begin
                unique case (state)
                    HDR: begin
                        if (is_status) begin
                            status_valid <= 1'b1;
                            status_pass  <= (hdr_type == 4'hE);
                            if (!dout.do_last) err_proto <= 1'b1;
                        end else begin
                            seg_type <= hdr_type;
                            seg_len  <= hdr_len;
                            rem      <= hdr_len;
                            if (hdr_len == 16'd0) seg_done <= 1'b1;
                            else                  state    <= DATA;
                            if (dout.do_last) err_proto <= 1'b1;
                        end
                    end
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_wdata <= dout.do_data;
                        mem_be    <= be_mask;
                        mem_addr  <= wr_ptr;
                        wr_ptr    <= wr_ptr + 1'b1;
                        byte_cnt  <= byte_cnt + take;
                        rem       <= rem_next;
                        // A premature last truncates the segment.
                        if (dout.do_last) begin
                            err_proto <= 1'b1;
                            seg_done  <= 1'b1;
                            rem       <= '0;
                            state     <= HDR;
                        end else if (rem_next == 16'd0) begin
                            seg_done <= 1'b1;
                            state    <= HDR;
                        end
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lwc_do_sink.sv
// Randomized scoreboard bench for lwc_do_sink.
// Segment-level model pushes expected writes, segment ends and statuses.
module tb_lwc_do_sink;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stall = 1'b0;
    always #5 clk = ~clk;

    lwc_do_sink_if #(.BUSW(32)) dout ();

    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [3:0]  seg_type;
    logic [15:0] seg_len;
    logic        seg_done;
    logic [15:0] byte_cnt;
    logic        status_valid;
    logic        status_pass;
    logic        err_proto;

    lwc_do_sink #(.BUSW(32), .ADDRW(8)) dut (
        .clk(clk),
        .rst(rst),
        .dout(dout),
        .stall(stall),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be(mem_be),
        .seg_type(seg_type),
        .seg_len(seg_len),
        .seg_done(seg_done),
        .byte_cnt(byte_cnt),
        .status_valid(status_valid),
        .status_pass(status_pass),
        .err_proto(err_proto)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [15:0] cnt;
    } wr_t;

    typedef struct {
        logic [3:0]  t;
        logic [15:0] len;
    } seg_t;

    typedef struct {
        logic pass;
        logic err;
    } st_t;

    wr_t  wq[$];
    seg_t sq[$];
    st_t  stq[$];

    int errors = 0;
    int checks = 0;
    int stall_mode = 0;

    logic [7:0]  mdl_addr = '0;
    logic [15:0] mdl_cnt = '0;
    logic        mdl_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Monitor: pops an expectation whenever the DUT presents an output event.
    always @(negedge clk) begin
        wr_t  w;
        seg_t s;
        st_t  st;
        if (rst) begin
            if (mem_we) begin
                if (wq.size() == 0) fail_now("spurious_write");
                else begin
                    w = wq.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(w.addr));
                    chk("wr_be", 32'(mem_be), 32'(w.be));
                    chk("wr_data", mem_wdata, w.data);
                    chk("wr_byte_cnt", 32'(byte_cnt), 32'(w.cnt));
                end
            end
            if (seg_done) begin
                if (sq.size() == 0) fail_now("spurious_seg_done");
                else begin
                    s = sq.pop_front();
                    chk("seg_type", 32'(seg_type), 32'(s.t));
                    chk("seg_len", 32'(seg_len), 32'(s.len));
                end
            end
            if (status_valid) begin
                if (stq.size() == 0) fail_now("spurious_status");
                else begin
                    st = stq.pop_front();
                    chk("status_pass", 32'(status_pass), 32'(st.pass));
                    chk("status_err", 32'(err_proto), 32'(st.err));
                end
            end
        end
    end

    // Backpressure generator.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (stall_mode)
                1: begin
                    ph++;
                    stall = ((ph / 2) % 2) == 1;
                end
                2: stall = ($urandom_range(0, 3) == 0);
                default: stall = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [31:0] w, input logic l);
        bit ok;
        ok = 0;
        dout.do_valid = 1'b1;
        dout.do_data  = w;
        dout.do_last  = l;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (dout.do_ready === 1'b1) ok = 1;
            @(posedge clk);
            #1;
        end
        dout.do_valid = 1'b0;
        if (!ok) fail_now("accept_timeout");
    endtask

    task automatic send_seg(input logic [3:0] t, input logic [15:0] len,
                            input int trunc, input bit pat);
        logic [31:0] hdr;
        logic [31:0] w;
        logic [3:0]  m;
        int nw, sent, b;
        hdr  = {t, 4'($urandom), 8'($urandom), len};
        nw   = (int'(len) + 3) / 4;
        sent = (trunc >= 0 && trunc < nw) ? trunc + 1 : nw;
        sq.push_back('{t, len});
        send(hdr, 1'b0);
        if (len == 16'd0) begin
            @(negedge clk);
            chk("empty_seg_done", 32'(seg_done), 32'd1);
            chk("empty_no_we", 32'(mem_we), 32'd0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < sent; i++) begin
            b = int'(len) - 4 * i;
            if (b > 4) b = 4;
            m = 4'hF;
            m = m << (4 - b);
            mdl_cnt = mdl_cnt + 16'(b);
            w = pat ? (32'h00010203 + 32'(i) * 32'h04040404) : $urandom;
            wq.push_back('{mdl_addr, m, w, mdl_cnt});
            mdl_addr = mdl_addr + 8'd1;
            send(w, i == trunc);
        end
        if (sent < nw) mdl_err = 1'b1;
    endtask

    task automatic send_status(input logic pass, input logic l);
        if (!l) mdl_err = 1'b1;
        stq.push_back('{pass, mdl_err});
        send({pass ? 4'hE : 4'hF, 28'h0}, l);
    endtask

    task automatic phase_end(input string name);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({name, "_byte_cnt"}, 32'(byte_cnt), 32'(mdl_cnt));
        chk({name, "_err_proto"}, 32'(err_proto), 32'(mdl_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dout.do_valid = 1'b1;
        dout.do_data  = 32'hE0000000;
        dout.do_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 32'(dout.do_ready), 32'd0);
            chk("rst_we", 32'(mem_we), 32'd0);
            chk("rst_status_valid", 32'(status_valid), 32'd0);
        end
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        chk("rst_seg_len", 32'(seg_len), 32'd0);
        chk("rst_err", 32'(err_proto), 32'd0);
        chk("rst_pass", 32'(status_pass), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dout.do_valid = 1'b0;
        @(negedge clk);
        chk("rel_ready_first", 32'(dout.do_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready_second", 32'(dout.do_ready), 32'd1);
        @(posedge clk);
        #1;

        send_seg(4'h5, 16'd32, -1, 1'b1);
        send_status(1'b1, 1'b1);
        phase_end("single");

        send_seg(4'h3, 16'd31, -1, 1'b0);
        send_seg(4'h7, 16'd0, -1, 1'b0);
        send_status(1'b1, 1'b1);
        phase_end("partial");

        stall_mode = 1;
        send_seg(4'h5, 16'd32, -1, 1'b0);
        send_status(1'b0, 1'b1);
        phase_end("stall");

        stall_mode = 2;
        for (int k = 0; k < 8; k++)
            send_seg(4'($urandom_range(0, 13)),
                     16'($urandom_range(0, 40)), -1, 1'b0);
        send_status(1'($urandom_range(0, 1)), 1'b1);
        phase_end("random");

        stall_mode = 0;
        send_seg(4'h5, 16'd32, 2, 1'b0);
        send_status(1'b0, 1'b1);
        phase_end("trunc");
        send_seg(4'h2, 16'd8, -1, 1'b0);
        phase_end("sticky");

        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("sq_empty", 32'(sq.size()), 32'd0);
        chk("stq_empty", 32'(stq.size()), 32'd0);

        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst2_err", 32'(err_proto), 32'd0);
        chk("rst2_byte_cnt", 32'(byte_cnt), 32'd0);
        chk("rst2_ready", 32'(dout.do_ready), 32'd0);
        chk("rst2_seg_type", 32'(seg_type), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lwc_do_sink.md
# lwc_do_sink

Synthesizable consumer for the `LWC` core's output port (`do_data` / `do_valid` / `do_ready` / `do_last`). It sits directly downstream of the core. It parses the output stream into segment headers, payload words and the final status word. Payload bytes are written to a byte-enabled capture memory port, and segment, byte-count and pass/fail results are reported. This lets FPGA and board-level runs check ciphertext and tag without a simulator.

## Interface
- BUSW, 32, data bus width in bits; multiple of 8, at least 32; matches `romulus_config_pkg`.
- ADDRW, 8, capture memory word-address width.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets).
- do_data  in  BUSW  output word from `LWC`.
- do_valid  in  1  `do_data` is valid.
- do_last  in  1  last word of the current output message.
- do_ready  out  1  sink accepts a word this cycle.
- stall  in  1  backpressure request; registered into `do_ready`.
- mem_we  out  1  capture write strobe.
- mem_addr  out  ADDRW  capture word address.
- mem_wdata  out  BUSW  captured payload word.
- mem_be  out  BUSW/8  byte enables; bit BUSW/8-1 covers `do_data[BUSW-1:BUSW-8]`, which is byte 0.
- seg_type  out  4  type field of the most recent header.
- seg_len  out  16  length field of the most recent header, in bytes.
- seg_done  out  1  one-cycle pulse when a segment's payload is complete.
- byte_cnt  out  16  total payload bytes captured since reset; wraps mod 2^16.
- status_valid  out  1  one-cycle pulse on status-word acceptance.
- status_pass  out  1  last status result: 1 = success (0xE), 0 = failure (0xF); held.
- err_proto  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- Word accepted when `do_valid & do_ready` at a rising edge. Nothing else changes any state.
- Header word fields:
  - type = `do_data[BUSW-1:BUSW-4]`
  - flags = `[BUSW-5:BUSW-8]`
  - length = `[15:0]`
- FSM states: HDR (reset state), DATA.
- HDR, accepted word with type 0xE or 0xF:
  - It is a status word. Pulse `status_valid`.
  - Set `status_pass` to (type==0xE).
  - If `do_last`==0, set `err_proto`.
  - Stay in HDR.
- HDR, any other type:
  - Load `seg_type` and `seg_len`; set `rem` = length.
  - If length==0: pulse `seg_done`, stay in HDR. This is the empty-segment case.
  - If length>0: go to DATA.
  - If `do_last`==1 on a non-status header, set `err_proto`.
- DATA, each accepted word:
  - Assert `mem_we` with `mem_wdata` = `do_data`.
  - `mem_be` = top min(rem, BUSW/8) bits set, MSB-first.
  - `mem_addr` post-increments, wrapping at 2^ADDRW.
  - `byte_cnt += min(rem, BUSW/8)`; `rem -= min(rem, BUSW/8)`.
  - When the new `rem`==0: pulse `seg_done`, go to HDR.
  - If `do_last`==1 in DATA: set `err_proto`, pulse `seg_done`, go to HDR. `rem` is discarded; this is a truncated segment.
- Bytes beyond `rem` in a partial final word are not enabled and are not counted.
- `rem` is 16 bits; the subtraction never underflows because of the min().

## Timing
- Reset values:
  - `do_ready`, `mem_we`, `seg_done`, `status_valid`, `err_proto`, `status_pass` = 0.
  - `mem_addr`, `mem_be`, `mem_wdata`, `seg_type`, `seg_len`, `byte_cnt` = 0.
  - FSM in HDR, `rem` = 0.
- `do_ready` is registered: `do_ready <= ~stall`, forced 0 while rst==0.
- After reset release, first `do_ready`=1 is one cycle after the first edge with rst==1 and stall==0.
- A stall change affects `do_ready` one cycle later. A word presented with `do_ready`=1 in that cycle is still accepted.
- All outputs are registered, one cycle after acceptance:
  - `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`
  - `seg_*`
  - `seg_done`, `status_*`, `err_proto`
  - `byte_cnt` updates in the same cycle as `mem_we`.
- Throughput is one word per cycle with no bubbles at segment boundaries.
- `do_valid` deasserting mid-segment holds all state; pulses do not fire.
- Reset mid-segment: everything returns to reset values on the next edge. A word offered in that same cycle is dropped.
- The core must hold `do_data` stable while `do_valid & ~do_ready`. The sink does not check this.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with `do_valid`=1 → no `mem_we`, `do_ready`=0; release → `do_ready`=1 on the second edge.
- **Single segment, then status:**
  - Stimulus: header 0x52000020 (type 5, length 32), 8 words 0x00010203…, then status 0xE0000000 with `do_last`=1.
  - Response: 8 writes to addr 0..7, `mem_be` all 1s, `seg_done` after word 8, `byte_cnt`=32, `status_valid`=1, `status_pass`=1, `err_proto`=0.
- **Partial word:**
  - Stimulus: header length 0x1F (31), 8 words.
  - Response: last write has `mem_be`=0b1110, `byte_cnt`=31; next word is parsed as a header.
- **Empty segment:** header length 0 → `seg_done` pulse one cycle after acceptance, no `mem_we`, FSM stays HDR.
- **Backpressure:** stall toggles 1/0 every 2 cycles through a 32-byte segment → every word captured exactly once, addresses 0..7 in order, `byte_cnt`=32.
- **Protocol errors:**
  - `do_last`=1 on the 3rd data word of a 32-byte segment → `err_proto`=1 and sticky, `seg_done` pulse; the next 0xF0000000 with `do_last` gives `status_pass`=0.
  - Then rst=0 → `err_proto` clears.
